// File: rtl/cmos_cap_pkg.sv
// -----------------------------------------------------------------------------
// cmos_cap_pkg
// Shared definitions for the OV5640 DVP capture path and its VGA-side reader:
// capture FSM states, RGB565 pixel layout, word geometry and the helper that
// drops a pixel into its slot of a 64-bit DDR word.
// -----------------------------------------------------------------------------
package cmos_cap_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_INIT,
        ST_SKIP,
        ST_ARM,
        ST_CAPTURE
    } cap_state_e;

    // RGB565 field layout, identical on the reader side.
    typedef struct packed {
        logic [4:0] r;  // [15:11]
        logic [5:0] g;  // [10:5]
        logic [4:0] b;  // [4:0]
    } rgb565_t;

    localparam int PIX_PER_WORD = 4;
    localparam int PIX_W        = 16;
    localparam int WORD_W       = PIX_PER_WORD * PIX_W;
    localparam int PIX_IDX_W    = 2;

    // Pixel 0 sits in the most significant slot, pixel 3 in the least, which
    // is the order the reader unpacks them.
    function automatic logic [WORD_W-1:0] place_pixel(
        input logic [WORD_W-1:0]    word,
        input rgb565_t              pix,
        input logic [PIX_IDX_W-1:0] idx
    );
        logic [WORD_W-1:0] res;
        res = word;
        case (idx)
            2'd0:    res[63:48] = pix;
            2'd1:    res[47:32] = pix;
            2'd2:    res[31:16] = pix;
            default: res[15:0]  = pix;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmos_word_pack.sv
// -----------------------------------------------------------------------------
// cmos_word_pack
// Pairs DVP bytes into RGB565 pixels, packs four pixels per 64-bit word and
// emits a one-cycle write strobe per word. A line end flushes a partial word
// with the missing pixels zero-filled.
//
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_en             packing allowed (capture active); low discards all state
//   i_byte_vld       stage-1 href: i_data carries a valid byte
//   i_line_start     href rising edge seen at stage 1 (restart pairing)
//   i_flush          line end: write the partial word, if any
//   i_data           stage-1 DVP byte
//   o_wren, o_wdata  write strobe and packed word
// -----------------------------------------------------------------------------
module cmos_word_pack
    import cmos_cap_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_byte_vld,
    input  logic              i_line_start,
    input  logic              i_flush,
    input  logic [7:0]        i_data,
    output logic              o_wren,
    output logic [WORD_W-1:0] o_wdata
);

    logic                 r_par;     // 1: high byte of the current pixel held
    logic [PIX_IDX_W-1:0] r_pix;     // slot of the next pixel
    logic [7:0]           r_hi;
    logic [WORD_W-1:0]    r_word;    // word under construction
    logic                 r_wren;
    logic [WORD_W-1:0]    r_wdata;

    logic                 w_par;
    logic [PIX_IDX_W-1:0] w_pix;
    logic [WORD_W-1:0]    w_word;
    rgb565_t              w_pixel;
    logic [WORD_W-1:0]    w_placed;

    // A line start overrides whatever pairing state the previous line left.
    // NOTE: every always_comb output is assigned on every path, so no latch.
    always_comb begin
        w_par    = i_line_start ? 1'b0 : r_par;
        w_pix    = i_line_start ? '0   : r_pix;
        w_word   = i_line_start ? '0   : r_word;
        w_pixel  = {r_hi, i_data};
        w_placed = place_pixel(w_word, w_pixel, w_pix);
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_par   <= 1'b0;
            r_pix   <= '0;
            r_hi    <= '0;
            r_word  <= '0;
            r_wren  <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_wren <= 1'b0;
            if (!i_en) begin
                r_par  <= 1'b0;
                r_pix  <= '0;
                r_word <= '0;
            end else if (i_flush) begin
                // A held high byte alone does not make a pixel; it is dropped.
                if (r_pix != '0 || r_par) begin
                    r_wren  <= 1'b1;
                    r_wdata <= r_word;
                end
                r_par  <= 1'b0;
                r_pix  <= '0;
                r_word <= '0;
            end else if (i_byte_vld) begin
                if (!w_par) begin
                    r_hi   <= i_data;
                    r_par  <= 1'b1;
                    r_pix  <= w_pix;
                    r_word <= w_word;
                end else begin
                    r_par <= 1'b0;
                    if (w_pix == PIX_IDX_W'(PIX_PER_WORD - 1)) begin
                        r_wren  <= 1'b1;
                        r_wdata <= w_placed;
                        r_word  <= '0;
                        r_pix   <= '0;
                    end else begin
                        r_word <= w_placed;
                        r_pix  <= w_pix + 1'b1;
                    end
                end
            end
        end
    end

    assign o_wren  = r_wren;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/cmos_ddr_write.sv
// -----------------------------------------------------------------------------
// cmos_ddr_write
// OV5640 DVP RGB565 capture in the pixel-clock domain. Registers the sensor
// inputs once, waits for DDR init, discards SKIP_FRAMES start-up frames, then
// packs each captured frame into 64-bit words for the DDR write FIFO and
// checks line/frame geometry.
//
// Ports:
//   cmos_pclk, cmos_rst_n            clock, synchronous active-low reset
//   cmos_vsync, cmos_href, cmos_data DVP inputs (vsync level per VSYNC_POL)
//   ddr_init_done                    DDR ready; low forces WAIT_INIT
//   ddr_wren, ddr_wdata              one-cycle write strobe and word
//   frame_start, frame_done          one-cycle frame pulses
//   frame_err                        sticky geometry error, cleared at frame_start
//   capturing                        high in CAPTURE
// -----------------------------------------------------------------------------
module cmos_ddr_write
    import cmos_cap_pkg::*;
#(
    parameter int H_PIX       = 1280,
    parameter int V_LINES     = 720,
    parameter int SKIP_FRAMES = 10,
    parameter bit VSYNC_POL   = 1'b1
) (
    input  logic              cmos_pclk,
    input  logic              cmos_rst_n,
    input  logic              cmos_vsync,
    input  logic              cmos_href,
    input  logic [7:0]        cmos_data,
    input  logic              ddr_init_done,
    output logic              ddr_wren,
    output logic [WORD_W-1:0] ddr_wdata,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err,
    output logic              capturing
);

    localparam logic [10:0] LINE_MAX = 11'h7FF;
    localparam logic [15:0] BYTE_MAX = 16'hFFFF;

    logic        r_vs1, r_vs2, r_href1, r_href2;
    logic [7:0]  r_data1;
    cap_state_e  r_state;
    logic [15:0] r_skip_cnt;
    logic [10:0] r_line_cnt;
    logic [15:0] r_byte_cnt;
    logic        r_frame_start, r_frame_done, r_done_pend, r_err;

    logic        w_vs_rise, w_vs_fall, w_href_rise, w_href_fall;
    logic        w_line_end, w_len_bad, w_pack_en;
    logic [10:0] w_lines_final;

    always_comb begin
        w_vs_rise   = (r_vs1 == VSYNC_POL) && (r_vs2 != VSYNC_POL);
        w_vs_fall   = (r_vs1 != VSYNC_POL) && (r_vs2 == VSYNC_POL);
        w_href_rise = r_href1 && !r_href2;
        w_href_fall = !r_href1 && r_href2;
        // vsync arriving with href still high ends the line as a boundary.
        w_line_end  = w_href_fall || (w_vs_rise && r_href1);
        w_len_bad   = (w_href_fall && r_byte_cnt != 16'(2 * H_PIX)) ||
                      (w_vs_rise && r_href1);
        w_lines_final = (w_href_fall && r_line_cnt != LINE_MAX) ?
                        r_line_cnt + 11'd1 : r_line_cnt;
        w_pack_en   = (r_state == ST_CAPTURE) && ddr_init_done;
    end

    always_ff @(posedge cmos_pclk) begin
        if (!cmos_rst_n) begin
            r_vs1         <= ~VSYNC_POL;
            r_vs2         <= ~VSYNC_POL;
            r_href1       <= 1'b0;
            r_href2       <= 1'b0;
            r_data1       <= '0;
            r_state       <= ST_WAIT_INIT;
            r_skip_cnt    <= '0;
            r_line_cnt    <= '0;
            r_byte_cnt    <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_done_pend   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_vs1         <= cmos_vsync;
            r_href1       <= cmos_href;
            r_data1       <= cmos_data;
            r_vs2         <= r_vs1;
            r_href2       <= r_href1;
            r_frame_start <= 1'b0;
            r_frame_done  <= r_done_pend;
            r_done_pend   <= 1'b0;

            if (!ddr_init_done) begin
                r_state      <= ST_WAIT_INIT;
                r_skip_cnt   <= '0;
                r_frame_done <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT_INIT: begin
                        r_skip_cnt <= '0;
                        r_state    <= (SKIP_FRAMES == 0) ? ST_ARM : ST_SKIP;
                    end
                    ST_SKIP: begin
                        if (w_vs_fall) begin
                            if (r_skip_cnt == 16'(SKIP_FRAMES - 1))
                                r_state <= ST_ARM;
                            else
                                r_skip_cnt <= r_skip_cnt + 16'd1;
                        end
                    end
                    ST_ARM: begin
                        // Holding off while a frame_done is pending keeps the
                        // two pulses in separate cycles.
                        if (w_vs_fall && !r_done_pend) begin
                            r_state       <= ST_CAPTURE;
                            r_frame_start <= 1'b1;
                            r_err         <= 1'b0;
                            r_line_cnt    <= '0;
                            r_byte_cnt    <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (r_href1)
                            r_byte_cnt <= w_href_rise ? 16'd1 :
                                          (r_byte_cnt == BYTE_MAX) ? BYTE_MAX :
                                          r_byte_cnt + 16'd1;
                        r_line_cnt <= w_lines_final;
                        if (w_len_bad)
                            r_err <= 1'b1;
                        if (w_vs_rise) begin
                            r_state <= ST_ARM;
                            if (w_lines_final != 11'(V_LINES))
                                r_err <= 1'b1;
                            // A flush strobe may go out this cycle; frame_done
                            // follows it one cycle later.
                            if (w_line_end)
                                r_done_pend <= 1'b1;
                            else
                                r_frame_done <= 1'b1;
                        end
                    end
                    default: r_state <= ST_WAIT_INIT;
                endcase
            end
        end
    end

    cmos_word_pack u_pack (
        .i_clk        (cmos_pclk),
        .i_rst_n      (cmos_rst_n),
        .i_en         (w_pack_en),
        .i_byte_vld   (r_href1),
        .i_line_start (w_href_rise),
        .i_flush      (w_line_end),
        .i_data       (r_data1),
        .o_wren       (ddr_wren),
        .o_wdata      (ddr_wdata)
    );

    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_err;
    assign capturing   = (r_state == ST_CAPTURE);

endmodule

// File: tb/tb_cmos_ddr_write.sv
// -----------------------------------------------------------------------------
// tb_cmos_ddr_write
// Drives DVP frames into cmos_ddr_write with a small frame geometry. The
// reference model treats each captured line as a big-endian byte stream cut
// into 8-byte words (a short tail is left-justified and zero-padded), and
// tracks frame capture/geometry from vsync-fall counts. A monitor pops and
// compares expected words, strobe cycles and frame_err at frame_done.
// -----------------------------------------------------------------------------
module tb_cmos_ddr_write;

    localparam int H_PIX       = 8;
    localparam int V_LINES     = 4;
    localparam int SKIP_FRAMES = 2;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmos_vsync, cmos_href, ddr_init_done;
    logic [7:0]  cmos_data;
    logic        ddr_wren, frame_start, frame_done, frame_err, capturing;
    logic [63:0] ddr_wdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_start = 0;
    int   n_done  = 0;
    exp_t exp_q[$];
    logic done_q[$];

    // Reference model state.
    bit m_init = 1'b0, m_cap = 1'b0, m_err = 1'b0;
    int m_falls = 0, m_lines = 0, m_exp_starts = 0, m_exp_dones = 0;

    logic [7:0] dir_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78,
                                  8'h9A, 8'hBC, 8'hDE, 8'hF0};

    cmos_ddr_write #(
        .H_PIX       (H_PIX),
        .V_LINES     (V_LINES),
        .SKIP_FRAMES (SKIP_FRAMES),
        .VSYNC_POL   (1'b1)
    ) dut (
        .cmos_pclk     (clk),
        .cmos_rst_n    (rst_n),
        .cmos_vsync    (cmos_vsync),
        .cmos_href     (cmos_href),
        .cmos_data     (cmos_data),
        .ddr_init_done (ddr_init_done),
        .ddr_wren      (ddr_wren),
        .ddr_wdata     (ddr_wdata),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .capturing     (capturing)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ddr_wren) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_wren");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wdata", ddr_wdata, e.data);
                    check("wren_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (frame_done) begin
                n_done++;
                if (done_q.size() == 0) note_fail("unexpected_frame_done");
                else check("frame_err_at_done", 64'(frame_err), 64'(done_q.pop_front()));
            end
            if (frame_start) begin
                n_start++;
                check("frame_err_at_start", 64'(frame_err), 64'd0);
                check("start_done_exclusive", 64'(frame_done), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        tick();
        cmos_vsync = 1'b1;
        if (m_cap) begin
            done_q.push_back(m_err || (m_lines != V_LINES));
            m_exp_dones++;
            m_cap = 1'b0;
        end
        repeat (3) tick();
        cmos_vsync = 1'b0;
        if (m_init) begin
            m_falls++;
            if (m_falls > SKIP_FRAMES) begin
                m_cap = 1'b1;
                m_err = 1'b0;
                m_lines = 0;
                m_exp_starts++;
            end
        end
        repeat (3) tick();
    endtask

    task automatic drive_line(input int nbytes, input bit directed);
        logic [63:0] w;
        int          cnt;
        w   = '0;
        cnt = 0;
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            b = (directed && i < 8) ? dir_bytes[i] : 8'($urandom);
            tick();
            cmos_href = 1'b1;
            cmos_data = b;
            w = {w[55:0], b};
            cnt++;
            if (cnt == 8) begin
                if (m_cap) exp_q.push_back('{w, cyc + 2});
                w   = '0;
                cnt = 0;
            end
        end
        tick();
        cmos_href = 1'b0;
        cmos_data = 8'($urandom);
        if (m_cap) begin
            if (cnt != 0) begin
                w = w << (8 * (8 - cnt));
                exp_q.push_back('{w, cyc + 2});
            end
            m_lines++;
            if (nbytes != 2 * H_PIX) m_err = 1'b1;
        end
        repeat (3) tick();
    endtask

    task automatic drive_frame(input int n_lines, input int short_line, input bit directed);
        vs_pulse();
        check("capturing_in_frame", 64'(capturing), 64'(m_cap));
        for (int l = 0; l < n_lines; l++)
            drive_line((l == short_line) ? 2 * (H_PIX - 2) : 2 * H_PIX, directed && l == 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cmos_vsync = 1'b0;
        cmos_href = 1'b0;
        cmos_data = '0;
        ddr_init_done = 1'b0;

        // Reset held with the sensor toggling.
        repeat (6) begin
            tick();
            cmos_href  = 1'($urandom);
            cmos_vsync = 1'($urandom);
            cmos_data  = 8'($urandom);
        end
        @(negedge clk);
        check("reset_ctrl_outputs", 64'({ddr_wren, frame_start, frame_done, frame_err, capturing}), 64'd0);
        check("reset_wdata", ddr_wdata, 64'd0);

        // Released, DDR not ready: nothing may happen.
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            cmos_href  = 1'($urandom);
            cmos_vsync = (i % 10) < 3;
            cmos_data  = 8'($urandom);
            if (i % 10 == 9) begin
                @(negedge clk);
                check("no_init_outputs", 64'({ddr_wren, frame_start, frame_done, frame_err, capturing}), 64'd0);
            end
        end
        tick();
        cmos_href = 1'b0;
        cmos_vsync = 1'b0;
        repeat (4) tick();
        ddr_init_done = 1'b1;
        m_init = 1'b1;
        repeat (4) tick();

        drive_frame(V_LINES, -1, 1'b0);  // skipped
        drive_frame(V_LINES, -1, 1'b0);  // skipped
        drive_frame(V_LINES, -1, 1'b0);  // first captured frame
        drive_frame(V_LINES, 1, 1'b0);   // short line -> error
        check("starts_after_f3", 64'(n_start), 64'(m_exp_starts));
        drive_frame(V_LINES, -1, 1'b0);  // clean frame clears error
        drive_frame(V_LINES - 1, -1, 1'b0); // missing line -> error
        drive_frame(V_LINES, -1, 1'b1);  // directed first word

        // Next frame starts capturing, then DDR init drops after 5 bytes.
        vs_pulse();
        check("capturing_before_drop", 64'(capturing), 64'(m_cap));
        for (int i = 0; i < 2 * H_PIX; i++) begin
            tick();
            cmos_href = 1'b1;
            cmos_data = 8'($urandom);
            if (i == 5) begin
                ddr_init_done = 1'b0;
                m_init = 1'b0;
                m_cap  = 1'b0;
                m_falls = 0;
            end
        end
        tick();
        cmos_href = 1'b0;
        repeat (3) tick();
        vs_pulse();
        repeat (20) tick();

        @(negedge clk);
        check("capturing_after_drop", 64'(capturing), 64'd0);
        check("words_outstanding", 64'(exp_q.size()), 64'd0);
        check("frame_done_outstanding", 64'(done_q.size()), 64'd0);
        check("frame_start_count", 64'(n_start), 64'(m_exp_starts));
        check("frame_done_count", 64'(n_done), 64'(m_exp_dones));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
